// File: rtl/cr_huf_comp_stcl_packer_pkg.sv
// ============================================================================
// Package : cr_huf_compPKG
// Purpose : Shared types, the deflate code-length permutation and the HCLEN
//           helper used by the small-tree code-length packer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cr_huf_compPKG;

   localparam int STCL_CL_MAX = 16;
   localparam int STCL_LEN_W  = 5;
   localparam int STCL_NPERM  = 19;

   typedef enum logic [1:0] {
      STCL_RAW     = 2'd0,
      STCL_DEFLATE = 2'd1,
      STCL_DELTA   = 2'd2,
      STCL_RSVD    = 2'd3
   } e_stcl_mode;

   typedef enum logic [1:0] {
      STCL_ST_IDLE  = 2'd0,
      STCL_ST_BUILD = 2'd1,
      STCL_ST_EMIT  = 2'd2
   } e_stcl_pack_st;

   typedef struct packed {
      logic [STCL_CL_MAX-1:0] value;
      logic [STCL_LEN_W-1:0]  length;
   } s_stcl_elem;

   // Entry 0 (rightmost) is the first symbol emitted in deflate order.
   localparam logic [STCL_NPERM-1:0][4:0] STCL_PERM = {
      5'd15, 5'd1, 5'd14, 5'd2, 5'd13, 5'd3, 5'd12, 5'd4, 5'd11, 5'd5,
      5'd10, 5'd6, 5'd9,  5'd7, 5'd8,  5'd0, 5'd18, 5'd17, 5'd16
   };

   // nz[p] flags a nonzero length at permuted position p.
   function automatic logic [3:0] stcl_hclen(input logic [STCL_NPERM-1:0] nz);
      int cnt;
      cnt = 4;
      for (int p = 0; p < STCL_NPERM; p++) begin
         if (nz[p] && (p + 1 > cnt)) cnt = p + 1;
      end
      return 4'(cnt - 4);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cr_huf_comp_stcl_packer_encode.sv
// ============================================================================
// Module  : cr_huf_comp_stcl_encode
// Purpose : Combinational element encoder: selects the code length at the
//           current index and returns its packed value, bit length, the
//           updated delta reference and the build element count.
//           Delta encoding present only with CR_HUF_COMP_STCL_DELTA_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cr_huf_comp_stcl_encode
   import cr_huf_compPKG::*;
#(
   parameter int NUM_SYM  = 33,
   parameter int CL_WIDTH = 4,
   parameter int CNT_W    = 6
) (
   input  logic [NUM_SYM*CL_WIDTH-1:0] snap_i,
   input  logic [CNT_W-1:0]            idx_i,
   input  e_stcl_mode                  mode_i,
   input  logic [CL_WIDTH-1:0]         prev_i,
   output s_stcl_elem                  elem_o,
   output logic [CL_WIDTH-1:0]         prev_o,
   output logic [CNT_W-1:0]            count_o
);

   logic [STCL_NPERM-1:0][CL_WIDTH-1:0] w_perm_len;
   logic [STCL_NPERM-1:0]               w_nz;
   logic [CL_WIDTH-1:0]                 w_raw;
   logic [2:0]                          w_dfl;

   for (genvar p = 0; p < STCL_NPERM; p++) begin : g_perm
      localparam int PI = int'(STCL_PERM[p]);
      if (PI < NUM_SYM) begin : g_in
         assign w_perm_len[p] = snap_i[PI*CL_WIDTH +: CL_WIDTH];
      end else begin : g_out
         assign w_perm_len[p] = '0;
      end
      assign w_nz[p] = |w_perm_len[p];
   end

   always_comb begin
      w_raw = '0;
      for (int i = 0; i < NUM_SYM; i++) begin
         if (idx_i == CNT_W'(i)) w_raw = snap_i[i*CL_WIDTH +: CL_WIDTH];
      end
      w_dfl = '0;
      for (int p = 0; p < STCL_NPERM; p++) begin
         if (idx_i == CNT_W'(p)) w_dfl = w_perm_len[p][2:0];
      end
   end

   assign count_o = (mode_i == STCL_DEFLATE) ? CNT_W'(stcl_hclen(w_nz)) + CNT_W'(4)
                                             : CNT_W'(NUM_SYM);

`ifdef CR_HUF_COMP_STCL_DELTA_EN
   logic [CL_WIDTH-1:0] w_dec;
   assign w_dec = w_raw - CL_WIDTH'(1);
`else
   logic w_unused_prev;
   assign w_unused_prev = ^prev_i;
`endif

   always_comb begin
      elem_o = '0;
      prev_o = prev_i;
      case (mode_i)
         STCL_DEFLATE: begin
            elem_o.value  = STCL_CL_MAX'(w_dfl);
            elem_o.length = STCL_LEN_W'(3);
         end
`ifdef CR_HUF_COMP_STCL_DELTA_EN
         STCL_DELTA: begin
            prev_o = w_raw;
            if (w_raw == prev_i) begin
               elem_o.length = STCL_LEN_W'(1);
            end else begin
               elem_o.length = STCL_LEN_W'(CL_WIDTH);
               // Upward steps store len-1 so the value range stays dense.
               if (w_raw > prev_i)
                  elem_o.value = STCL_CL_MAX'({w_dec[CL_WIDTH-2:0], 1'b1});
               else
                  elem_o.value = STCL_CL_MAX'({w_raw[CL_WIDTH-2:0], 1'b1});
            end
         end
`endif
         default: begin
            elem_o.value  = STCL_CL_MAX'(w_raw);
            elem_o.length = STCL_LEN_W'(CL_WIDTH);
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/cr_huf_comp_stcl_packer.sv
// ============================================================================
// Module  : cr_huf_comp_stcl_packer
// Purpose : Snapshots a code-length vector and serialises it LSB-first into
//           WORD_WIDTH words (raw / deflate / delta) over valid/ready.
//           Delta mode enabled by defining CR_HUF_COMP_STCL_DELTA_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cr_huf_comp_stcl_packer
   import cr_huf_compPKG::*;
#(
   parameter int NUM_SYM    = 33,
   parameter int CL_WIDTH   = 4,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int SIZE_WIDTH = $clog2(NUM_SYM*CL_WIDTH+1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [1:0]                  mode,
   input  logic [NUM_SYM*CL_WIDTH-1:0] sym_dpth,
   input  logic                        abort,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WORD_WIDTH-1:0]       out_data,
   output logic [ADDR_WIDTH-1:0]       out_addr,
   output logic                        out_last,
   output logic                        busy,
   output logic                        done,
   output logic [SIZE_WIDTH-1:0]       stcl_size,
   output logic [3:0]                  hclen
);

   localparam int AW    = WORD_WIDTH + CL_WIDTH;
   localparam int FW    = $clog2(AW + 1);
   localparam int CNT_W = $clog2(((NUM_SYM > STCL_NPERM) ? NUM_SYM : STCL_NPERM) + 1);

   e_stcl_pack_st               state_q, state_d;
   e_stcl_mode                  mode_q, mode_d, w_mode_sel;
   logic [NUM_SYM*CL_WIDTH-1:0] snap_q, snap_d;
   logic [AW-1:0]               acc_q, acc_d;
   logic [FW-1:0]               fill_q, fill_d, w_fill_sum;
   logic [CNT_W-1:0]            idx_q, idx_d, w_idx_inc, w_count;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic [SIZE_WIDTH-1:0]       size_q, size_d;
   logic [3:0]                  hclen_q, hclen_d;
   logic                        valid_q, valid_d, last_q, last_d;
   logic                        done_q, done_d, busy_q, busy_d;
   logic [CL_WIDTH-1:0]         w_prev, w_prev_next;
   logic [CL_WIDTH-1:0]         w_val;
   s_stcl_elem                  w_elem;

`ifdef CR_HUF_COMP_STCL_DELTA_EN
   logic [CL_WIDTH-1:0] prev_q, prev_d;
   assign w_prev = prev_q;
`else
   logic w_unused_prev_next;
   assign w_prev             = CL_WIDTH'(4);
   assign w_unused_prev_next = ^w_prev_next;
`endif

   cr_huf_comp_stcl_encode #(
      .NUM_SYM  (NUM_SYM),
      .CL_WIDTH (CL_WIDTH),
      .CNT_W    (CNT_W)
   ) u_encode (
      .snap_i  (snap_q),
      .idx_i   (idx_q),
      .mode_i  (mode_q),
      .prev_i  (w_prev),
      .elem_o  (w_elem),
      .prev_o  (w_prev_next),
      .count_o (w_count)
   );

   assign w_val = w_elem.value[CL_WIDTH-1:0];
   if (CL_WIDTH < STCL_CL_MAX) begin : g_val_pad
      logic w_unused_val;
      assign w_unused_val = ^w_elem.value[STCL_CL_MAX-1:CL_WIDTH];
   end

   always_comb begin
      case (e_stcl_mode'(mode))
         STCL_DEFLATE: w_mode_sel = STCL_DEFLATE;
`ifdef CR_HUF_COMP_STCL_DELTA_EN
         STCL_DELTA:   w_mode_sel = STCL_DELTA;
`endif
         default:      w_mode_sel = STCL_RAW;
      endcase
   end

   assign w_fill_sum = fill_q + FW'(w_elem.length);
   assign w_idx_inc  = idx_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      snap_d  = snap_q;
      acc_d   = acc_q;
      fill_d  = fill_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      size_d  = size_q;
      hclen_d = hclen_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = 1'b0;
`ifdef CR_HUF_COMP_STCL_DELTA_EN
      prev_d  = prev_q;
`endif
      case (state_q)
         STCL_ST_IDLE: begin
            if (start) begin
               state_d = STCL_ST_BUILD;
               mode_d  = w_mode_sel;
               snap_d  = sym_dpth;
               acc_d   = '0;
               fill_d  = '0;
               idx_d   = '0;
               addr_d  = '0;
               size_d  = '0;
               hclen_d = '0;
               valid_d = 1'b0;
               last_d  = 1'b0;
`ifdef CR_HUF_COMP_STCL_DELTA_EN
               prev_d  = CL_WIDTH'(4);
`endif
            end
         end
         STCL_ST_BUILD: begin
            acc_d   = acc_q | (AW'(w_val) << fill_q);
            fill_d  = w_fill_sum;
            idx_d   = w_idx_inc;
            size_d  = size_q + SIZE_WIDTH'(w_elem.length);
            hclen_d = (mode_q == STCL_DEFLATE) ? 4'(w_count - CNT_W'(4)) : 4'd0;
`ifdef CR_HUF_COMP_STCL_DELTA_EN
            prev_d  = w_prev_next;
`endif
            if ((w_fill_sum >= FW'(WORD_WIDTH)) || (w_idx_inc == w_count)) begin
               state_d = STCL_ST_EMIT;
               valid_d = 1'b1;
               last_d  = (w_idx_inc == w_count) && (w_fill_sum <= FW'(WORD_WIDTH));
            end
         end
         STCL_ST_EMIT: begin
            if (valid_q && out_ready) begin
               acc_d  = acc_q >> WORD_WIDTH;
               fill_d = (fill_q > FW'(WORD_WIDTH)) ? fill_q - FW'(WORD_WIDTH) : '0;
               addr_d = addr_q + ADDR_WIDTH'(1);
               if (last_q) begin
                  state_d = STCL_ST_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (idx_q == w_count) begin
                  // Overflow bits from the final element form one more word.
                  last_d = 1'b1;
               end else begin
                  state_d = STCL_ST_BUILD;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = STCL_ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
      if (abort) begin
         state_d = STCL_ST_IDLE;
         valid_d = 1'b0;
         last_d  = 1'b0;
         done_d  = 1'b0;
      end
      busy_d = (state_d != STCL_ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STCL_ST_IDLE;
         mode_q  <= STCL_RAW;
         snap_q  <= '0;
         acc_q   <= '0;
         fill_q  <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         size_q  <= '0;
         hclen_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef CR_HUF_COMP_STCL_DELTA_EN
         prev_q  <= CL_WIDTH'(4);
`endif
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         snap_q  <= snap_d;
         acc_q   <= acc_d;
         fill_q  <= fill_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         hclen_q <= hclen_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef CR_HUF_COMP_STCL_DELTA_EN
         prev_q  <= prev_d;
`endif
      end
   end

   assign out_valid = valid_q;
   assign out_data  = acc_q[WORD_WIDTH-1:0];
   assign out_addr  = addr_q;
   assign out_last  = last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign stcl_size = size_q;
   assign hclen     = hclen_q;

endmodule

`default_nettype wire
